// File: rtl/spike_rate_classifier.sv
// Output stage for the SNN: accumulates NUM_STEPS int8 vectors per class with
// saturation, then scans serially for the winning class and reports it.
module spike_rate_classifier #(
    parameter int                NUM_CLASSES      = 10,
    parameter int                NUM_STEPS        = 8,
    parameter int                DATA_WIDTH       = 8,
    parameter int                ACC_WIDTH        = 16,
    parameter logic signed [8:0] INPUT_ZERO_POINT = 9'sd0,
    localparam int               IDX_W            = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [IDX_W-1:0]              o_class,
    output logic [ACC_WIDTH-1:0]          o_score
);

    localparam int FC_W   = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int DIFF_W = ((DATA_WIDTH > 9) ? DATA_WIDTH : 9) + 1;
    localparam int SUM_W  = ((ACC_WIDTH > DIFF_W) ? ACC_WIDTH : DIFF_W) + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]            IDX_LAST   = IDX_W'(NUM_CLASSES - 1);
    localparam logic [FC_W-1:0]             FRAME_LAST = FC_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_MAX, S_DONE} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic [FC_W-1:0]               frame_cnt;
    logic signed [DATA_WIDTH-1:0]  vec [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]   acc [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]   best_val;
    logic [IDX_W-1:0]              best_idx;

    logic signed [DIFF_W-1:0]      diff;
    logic signed [SUM_W-1:0]       sum;
    logic signed [ACC_WIDTH-1:0]   sat_val;
    logic signed [ACC_WIDTH-1:0]   cur_val;
    logic                          take;
    logic signed [ACC_WIDTH-1:0]   nxt_best_val;
    logic [IDX_W-1:0]              nxt_best_idx;

    assign i_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    // Sum is wide enough that both the zero-point shift and the accumulate
    // can never wrap before the clamp sees them.
    // NOTE: every always_comb output gets a value on all paths, so no latch is inferred.
    always_comb begin
        diff    = DIFF_W'(vec[idx]) - DIFF_W'(INPUT_ZERO_POINT);
        sum     = SUM_W'(acc[idx]) + SUM_W'(diff);
        sat_val = ACC_WIDTH'(sum);
        if (sum > SUM_W'(ACC_MAX))
            sat_val = ACC_MAX;
        else if (sum < SUM_W'(ACC_MIN))
            sat_val = ACC_MIN;

        cur_val      = acc[idx];
        take         = (idx == '0) || (cur_val > best_val);
        nxt_best_val = take ? cur_val : best_val;
        nxt_best_idx = take ? idx : best_idx;
    end

    // NOTE: the vector register has no reset; it is always written before S_ACC reads it.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && i_valid) begin
            for (int k = 0; k < NUM_CLASSES; k++)
                vec[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            frame_cnt <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            o_class   <= '0;
            o_score   <= '0;
            for (int k = 0; k < NUM_CLASSES; k++)
                acc[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        idx   <= '0;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc[idx] <= sat_val;
                    if (idx == IDX_LAST) begin
                        if (frame_cnt == FRAME_LAST) begin
                            idx   <= '0;
                            state <= S_MAX;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_MAX: begin
                    best_val <= nxt_best_val;
                    best_idx <= nxt_best_idx;
                    if (idx == IDX_LAST) begin
                        o_class <= nxt_best_idx;
                        o_score <= nxt_best_val;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        frame_cnt <= '0;
                        for (int k = 0; k < NUM_CLASSES; k++)
                            acc[k] <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_classifier.sv
// Directed bench: three 4-class/3-step instances (plain, 8-bit accumulators,
// zero point 10) share stimulus; sel picks which one a scenario drives.
module tb_spike_rate_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
    logic [1:0]  cls0, cls1, cls2;
    logic [15:0] scr0, scr2;
    logic [7:0]  scr1;

    logic               cur_ready, cur_valid;
    logic [1:0]         cur_class;
    logic signed [15:0] cur_score;

    always #5 clk = ~clk;

    spike_rate_classifier #(.NUM_CLASSES(4), .NUM_STEPS(3), .DATA_WIDTH(8),
                            .ACC_WIDTH(16), .INPUT_ZERO_POINT(9'sd0)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid && sel == 0), .i_ready(rdy0),
        .i_data(i_data), .o_valid(vld0), .o_ready(o_ready), .o_class(cls0), .o_score(scr0));

    spike_rate_classifier #(.NUM_CLASSES(4), .NUM_STEPS(3), .DATA_WIDTH(8),
                            .ACC_WIDTH(8), .INPUT_ZERO_POINT(9'sd0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid && sel == 1), .i_ready(rdy1),
        .i_data(i_data), .o_valid(vld1), .o_ready(o_ready), .o_class(cls1), .o_score(scr1));

    spike_rate_classifier #(.NUM_CLASSES(4), .NUM_STEPS(3), .DATA_WIDTH(8),
                            .ACC_WIDTH(16), .INPUT_ZERO_POINT(9'sd10)) dut_zp (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid && sel == 2), .i_ready(rdy2),
        .i_data(i_data), .o_valid(vld2), .o_ready(o_ready), .o_class(cls2), .o_score(scr2));

    always_comb begin
        cur_ready = rdy0;
        cur_valid = vld0;
        cur_class = cls0;
        cur_score = scr0;
        if (sel == 1) begin
            cur_ready = rdy1;
            cur_valid = vld1;
            cur_class = cls1;
            cur_score = {{8{scr1[7]}}, scr1};
        end else if (sel == 2) begin
            cur_ready = rdy2;
            cur_valid = vld2;
            cur_class = cls2;
            cur_score = scr2;
        end
    end

    function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_frame(input logic [31:0] v);
        int waited = 0;
        while (!cur_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cur_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: i_ready=%0b after %0d cycles, required 1", cur_ready, waited);
        end else begin
            i_data  = v;
            i_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic run_batch(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2);
        send_frame(f0);
        send_frame(f1);
        send_frame(f2);
    endtask

    task automatic wait_valid();
        int waited = 0;
        while (!cur_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cur_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: o_valid=%0b after %0d cycles, required 1", cur_valid, waited);
        end
    endtask

    task automatic expect_result(input string name, input logic [1:0] exp_class,
                                 input logic signed [15:0] exp_score);
        wait_valid();
        checks++;
        if (cur_class !== exp_class) begin
            errors++;
            $display("FAIL %s_class: got %0d required %0d", name, cur_class, exp_class);
        end
        checks++;
        if (cur_score !== exp_score) begin
            errors++;
            $display("FAIL %s_score: got %0d required %0d", name, cur_score, exp_score);
        end
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        checks++;
        if (cur_valid !== 1'b0 || cur_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_consume: o_valid=%0b i_ready=%0b required 0/1", name, cur_valid, cur_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({vld0, vld1, vld2} !== 3'b000 || cls0 !== 2'd0 || scr0 !== 16'd0 || scr1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: o_valid=%b o_class=%0d o_score=%0d/%0d required 0",
                     {vld0, vld1, vld2}, cls0, scr0, scr1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy0, rdy1, rdy2} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: i_ready=%b required 111", {rdy0, rdy1, rdy2});
        end
    endtask

    // i_ready low on cycles 1..4 after a non-final handshake, high on cycle 5.
    task automatic check_ready_gap(input string name);
        for (int n = 1; n <= 5; n++) begin
            checks++;
            if (cur_ready !== (n == 5)) begin
                errors++;
                $display("FAIL %s_ready_c%0d: got %0b required %0b", name, n, cur_ready, (n == 5));
            end
            if (n < 5) @(negedge clk);
        end
    endtask

    task automatic test_basic();
        sel = 0;
        send_frame(pack4(1, 2, 3, 4));
        check_ready_gap("basic_f0");
        send_frame(pack4(5, -1, 0, 0));
        check_ready_gap("basic_f1");
        send_frame(pack4(0, 0, 0, -10));
        for (int n = 1; n <= 9; n++) begin
            checks++;
            if (cur_valid !== (n == 9)) begin
                errors++;
                $display("FAIL basic_latency_c%0d: o_valid=%0b required %0b", n, cur_valid, (n == 9));
            end
            if (n < 9) @(negedge clk);
        end
        expect_result("basic", 2'd0, 16'sd6);
    endtask

    task automatic test_tie_negative();
        sel = 0;
        run_batch(pack4(1, 3, 4, 0), pack4(1, 4, 3, 1), pack4(0, 0, 0, 0));
        expect_result("tie", 2'd1, 16'sd7);
        run_batch(pack4(-2, -1, -3, -1), pack4(-2, -1, -3, -1), pack4(-1, -1, -3, -2));
        expect_result("negative", 2'd1, -16'sd3);
    endtask

    task automatic test_saturation();
        sel = 1;
        run_batch(pack4(-128, 0, 127, 0), pack4(-128, 0, 127, 0), pack4(-128, 0, 127, 0));
        expect_result("sat_pos", 2'd2, 16'sd127);
        // Class 0 sums to -256: a wrap would leave 0 and win with score 0.
        run_batch(pack4(-128, -100, -100, -100), pack4(-128, -100, -100, -100),
                  pack4(0, -100, -100, -100));
        expect_result("sat_neg", 2'd0, -16'sd128);
    endtask

    task automatic test_zero_point();
        sel = 2;
        run_batch(pack4(10, 10, 10, 20), pack4(10, 10, 10, 20), pack4(10, 10, 10, 20));
        expect_result("zero_point", 2'd3, 16'sd30);
    endtask

    task automatic test_backpressure();
        sel = 0;
        run_batch(pack4(5, 0, 0, 0), pack4(5, 0, 0, 0), pack4(5, 0, 0, 0));
        wait_valid();
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (cur_valid !== 1'b1 || cur_ready !== 1'b0 || cur_class !== 2'd0 || cur_score !== 16'sd15) begin
                errors++;
                $display("FAIL hold_c%0d: valid=%0b ready=%0b class=%0d score=%0d required 1/0/0/15",
                         n, cur_valid, cur_ready, cur_class, cur_score);
            end
            @(negedge clk);
        end
        expect_result("hold", 2'd0, 16'sd15);
        run_batch(pack4(0, 2, 0, 0), pack4(0, 2, 0, 0), pack4(0, 2, 0, 0));
        expect_result("reuse", 2'd1, 16'sd6);
    endtask

    task automatic test_mid_reset();
        sel = 0;
        run_batch(pack4(9, 0, 0, 0), pack4(9, 0, 0, 0), pack4(9, 0, 0, 0));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cur_valid !== 1'b0 || cur_class !== 2'd0 || cur_score !== 16'sd0 || cur_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b class=%0d score=%0d ready=%0b required 0/0/0/1",
                     cur_valid, cur_class, cur_score, cur_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_batch(pack4(0, 0, 3, 0), pack4(0, 0, 3, 0), pack4(0, 0, 3, 0));
        expect_result("after_reset", 2'd2, 16'sd9);
    endtask

    initial begin
        rst_n   = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_data  = '0;
        sel     = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie_negative();
        test_saturation();
        test_zero_point();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_classifier.md
Name: spike_rate_classifier

Overview:
- Output stage placed directly downstream of the final dense_layer.
- Accepts NUM_STEPS int8 output vectors (one per SNN timestep) over a valid/ready handshake.
- Accumulates them element-serially into per-class signed saturating accumulators.
- After the last timestep, scans the accumulators serially and presents the winning class index and its score on a valid/ready output.

Parameters:
- NUM_CLASSES, 10: number of int8 elements per input vector (= upstream OUTPUT_SIZE).
- NUM_STEPS, 8: number of input vectors accumulated per classification.
- DATA_WIDTH, 8: element width, signed.
- ACC_WIDTH, 16: per-class accumulator width, signed, saturating.
- INPUT_ZERO_POINT, 0: signed 9-bit; subtracted from every element before accumulation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input vector valid.
- i_ready  out  1  block can accept a vector.
- i_data  in  NUM_CLASSES*DATA_WIDTH  signed vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_valid  out  1  result valid.
- o_ready  in  1  consumer accepts result.
- o_class  out  max(1,$clog2(NUM_CLASSES))  winning class index.
- o_score  out  ACC_WIDTH  signed accumulator value of the winning class.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=S_IDLE; all accumulators, frame counter, element index and best registers cleared.
  - o_class=0, o_score=0, o_valid=0, i_ready=1 once rst_n deasserts.
- Outputs:
  - i_ready = (state==S_IDLE); o_valid = (state==S_DONE). Both decoded from state, no combinational path from i_valid/o_ready.
  - o_class and o_score are registered, stable for the whole time o_valid is high.
- S_IDLE:
  - On i_valid&&i_ready: latch i_data into a vector register, idx<=0, go to S_ACC.
  - i_data is ignored outside this cycle.
- S_ACC, one element per cycle, N=NUM_CLASSES cycles:
  - diff = sign-extend(elem[idx]) - INPUT_ZERO_POINT (10-bit signed).
  - acc[idx] <= sat(acc[idx] + diff), where sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Overflow is detected on an ACC_WIDTH+1-bit sum; no wrap-around is permitted.
  - After idx==N-1:
    - If frame_cnt==NUM_STEPS-1: idx<=0, go to S_MAX.
    - Otherwise: frame_cnt++, go to S_IDLE.
- S_MAX, N cycles, idx 0..N-1:
  - idx 0 loads best_val=acc[0], best_idx=0 unconditionally.
  - For idx>0, replace only if acc[idx] > best_val (strict, signed compare). Ties resolve to the lowest index.
  - After idx==N-1: o_class<=best_idx, o_score<=best_val (final compare included), go to S_DONE.
- S_DONE:
  - Hold until o_ready.
  - On o_valid&&o_ready: clear all accumulators and frame_cnt in one cycle, go to S_IDLE.
  - o_class/o_score retain their values until the next result is written.
- Timing, with the input handshake at cycle 0:
  - Non-final frame: i_ready low for cycles 1..N, high again at cycle N+1.
  - Final frame: S_ACC covers cycles 1..N, S_MAX covers N+1..2N, and o_valid rises at cycle 2N+1.
  - Throughput: one vector per N+1 cycles minimum.
- Backpressure: with o_ready low indefinitely, the block stays in S_DONE and i_ready stays 0.
- NUM_STEPS=1: every accepted vector yields a result directly.

Test Plan:
- NUM_CLASSES=4, NUM_STEPS=3, ZP=0; frames [1,2,3,4], [5,-1,0,0], [0,0,0,-10] -> sums [6,1,3,-6]; o_class=0, o_score=6. o_valid rises exactly 9 cycles after the third input handshake. i_ready is low exactly 4 cycles after each of the first two handshakes.
- Tie and negative values: frames producing sums [2,7,7,1] -> o_class=1, o_score=7. All-negative sums [-5,-3,-9,-4] -> o_class=1, o_score=-3.
- Saturation, ACC_WIDTH=8: class 2 receives 127 in each of 3 frames -> o_score=127. Class 0 receives -128 ×3 -> acc stays -128, no wrap.
- Zero point, INPUT_ZERO_POINT=10: frames all 10 except class 3 = 20 in each of 3 frames -> o_class=3, o_score=30.
- Backpressure and reuse: hold o_ready=0 for 20 cycles -> o_valid, o_class, o_score stable and i_ready=0. Release o_ready, then run a second batch -> its result is independent of the first (accumulators cleared).
- Mid-operation reset: assert rst_n=0 during S_MAX of a batch -> o_valid=0 and o_class=0 immediately. A subsequent full batch yields the correct result with no residue from the aborted batch.
